// File: rtl/run_length_detector_if.sv
// -----------------------------------------------------------------------------
// run_length_detector_if
// Groups the sample-side and status-side signals of run_length_detector.
//   master : drives en, w, overlap, clear; observes the status outputs
//   slave  : the detector itself (consumes samples, drives status)
// Signals:
//   en        sample qualifier
//   w         serial data bit
//   overlap   1 = overlapping detection, 0 = non-overlapping
//   clear     synchronous soft clear (hit_count unaffected)
//   z         hit flag
//   z_one     hit is a run of ones
//   z_zero    hit is a run of zeros
//   state     one-hot state {RUN1, RUN0, IDLE}
//   run_cnt   current run length
//   hit_count saturating hit counter
// -----------------------------------------------------------------------------
interface run_length_detector_if #(
  parameter int RUN_LEN = 4,
  parameter int HIT_W   = 8
);
  localparam int CNT_W = $clog2(RUN_LEN + 1);

  logic             en;
  logic             w;
  logic             overlap;
  logic             clear;
  logic             z;
  logic             z_one;
  logic             z_zero;
  logic [2:0]       state;
  logic [CNT_W-1:0] run_cnt;
  logic [HIT_W-1:0] hit_count;

  modport master (
    output en, w, overlap, clear,
    input  z, z_one, z_zero, state, run_cnt, hit_count
  );

  modport slave (
    input  en, w, overlap, clear,
    output z, z_one, z_zero, state, run_cnt, hit_count
  );
endinterface

// File: rtl/run_length_detector.sv
// -----------------------------------------------------------------------------
// run_length_detector
// Flags RUN_LEN consecutive equal bits (all zeros or all ones) on a serial
// input sampled on enabled clock edges. Supports overlapping and
// non-overlapping detection, a synchronous soft clear and a saturating hit
// counter. Every output is a function of registers only.
// Ports:
//   clk     in  rising-edge clock
//   resetn  in  synchronous, active-low reset
//   bus     slave modport of run_length_detector_if (samples in, status out)
// Parameters:
//   RUN_LEN consecutive equal bits for a hit (2..255)
//   HIT_W   width of hit_count
// -----------------------------------------------------------------------------
module run_length_detector #(
  parameter int RUN_LEN = 4,
  parameter int HIT_W   = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  run_length_detector_if.slave  bus
);

  localparam int               CNT_W     = $clog2(RUN_LEN + 1);
  localparam logic [CNT_W-1:0] RUN_LEN_C = CNT_W'(RUN_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [HIT_W-1:0] HIT_MAX   = {HIT_W{1'b1}};

  localparam logic [2:0] S_IDLE = 3'b001;
  localparam logic [2:0] S_RUN0 = 3'b010;
  localparam logic [2:0] S_RUN1 = 3'b100;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_run_cnt;
  logic [HIT_W-1:0] r_hit_count;

  logic [2:0]       w_state_next;
  logic [CNT_W-1:0] w_run_cnt_next;
  logic             w_hit;
  logic             w_same;
  logic             w_z;

  // State register: state, run length and hit counter move together.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_run_cnt   <= '0;
      r_hit_count <= '0;
    end else begin
      r_state   <= w_state_next;
      r_run_cnt <= w_run_cnt_next;
      if (w_hit && (r_hit_count != HIT_MAX)) begin
        r_hit_count <= r_hit_count + 1'b1;
      end
    end
  end

  // Next-state logic. Clear outranks the sample; en=0 holds everything.
  always_comb begin
    w_state_next   = r_state;
    w_run_cnt_next = r_run_cnt;
    w_hit          = 1'b0;
    w_same         = (r_state == S_RUN1) ? bus.w : ~bus.w;

    if (bus.clear) begin
      w_state_next   = S_IDLE;
      w_run_cnt_next = '0;
    end else if (bus.en) begin
      case (r_state)
        S_RUN0, S_RUN1: begin
          if (!w_same) begin
            w_state_next   = bus.w ? S_RUN1 : S_RUN0;
            w_run_cnt_next = CNT_ONE;
          end else if (r_run_cnt < RUN_LEN_C) begin
            w_run_cnt_next = r_run_cnt + CNT_ONE;
          end else if (bus.overlap) begin
            w_run_cnt_next = RUN_LEN_C;
          end else begin
            w_run_cnt_next = CNT_ONE;
          end
        end
        default: begin
          // IDLE, and recovery from any non-one-hot encoding.
          w_state_next   = bus.w ? S_RUN1 : S_RUN0;
          w_run_cnt_next = CNT_ONE;
        end
      endcase
      // Every consumed sample that leaves the run at full length is a hit,
      // including each extra equal bit while saturated in overlap mode.
      w_hit = (w_run_cnt_next == RUN_LEN_C);
    end
  end

  // Output decode from registers only.
  always_comb begin
    w_z           = (r_run_cnt == RUN_LEN_C);
    bus.z         = w_z;
    bus.z_one     = w_z & (r_state == S_RUN1);
    bus.z_zero    = w_z & (r_state == S_RUN0);
    bus.state     = r_state;
    bus.run_cnt   = r_run_cnt;
    bus.hit_count = r_hit_count;
  end

endmodule

// File: tb/tb_run_length_detector.sv
module tb_run_length_detector;

  logic clk;
  logic resetn;
  int   checks;
  int   failures;

  typedef struct packed {
    logic [2:0] st;
    logic [2:0] cnt;
    logic       z;
    logic       z1;
    logic       z0;
    logic [7:0] hit;
  } obs_t;

  obs_t sb_q[$];
  logic [1:0] sat_q[$];

  run_length_detector_if #(.RUN_LEN(4), .HIT_W(8)) bus ();
  run_length_detector_if #(.RUN_LEN(4), .HIT_W(2)) bus2 ();

  run_length_detector #(.RUN_LEN(4), .HIT_W(8)) dut (
    .clk(clk), .resetn(resetn), .bus(bus)
  );

  run_length_detector #(.RUN_LEN(4), .HIT_W(2)) dut2 (
    .clk(clk), .resetn(resetn), .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected observation; z flags follow from state and count.
  function automatic obs_t mk(input logic [2:0] st, input int cnt, input int hit);
    obs_t o;
    o.st  = st;
    o.cnt = 3'(cnt);
    o.z   = (cnt == 4);
    o.z1  = (cnt == 4) && (st == 3'b100);
    o.z0  = (cnt == 4) && (st == 3'b010);
    o.hit = 8'(hit);
    return o;
  endfunction

  function automatic obs_t get_obs();
    obs_t o;
    o.st  = bus.state;
    o.cnt = bus.run_cnt;
    o.z   = bus.z;
    o.z1  = bus.z_one;
    o.z0  = bus.z_zero;
    o.hit = bus.hit_count;
    return o;
  endfunction

  // One clock edge with the given inputs on both DUTs; returns at the
  // following falling edge, where outputs are stable.
  task automatic drive(input logic rn, input logic en, input logic w,
                       input logic ov, input logic clr);
    resetn       = rn;
    bus.en       = en;  bus2.en      = en;
    bus.w        = w;   bus2.w       = w;
    bus.overlap  = ov;  bus2.overlap = ov;
    bus.clear    = clr; bus2.clear   = clr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    obs_t got, exp;
    for (int i = 0; i < 2; i++) begin
      sb_q.push_back(mk(3'b001, 0, 0));
      drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      got = get_obs();
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL reset cyc=%0d got st=%b cnt=%0d z=%b%b%b hit=%0d req st=%b cnt=%0d z=%b%b%b hit=%0d",
                 i, got.st, got.cnt, got.z, got.z1, got.z0, got.hit,
                 exp.st, exp.cnt, exp.z, exp.z1, exp.z0, exp.hit);
      end else $display("reset cyc=%0d st=%b cnt=%0d ok", i, got.st, got.cnt);
    end
  endtask

  task automatic test_overlap_ones();
    obs_t got, exp;
    logic w_tab [6]   = '{1, 1, 1, 1, 1, 0};
    int   cnt_tab [6] = '{1, 2, 3, 4, 4, 1};
    int   hit_tab [6] = '{0, 0, 0, 1, 2, 2};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      sb_q.push_back(mk(w_tab[i] ? 3'b100 : 3'b010, cnt_tab[i], hit_tab[i]));
      drive(1'b1, 1'b1, w_tab[i], 1'b1, 1'b0);
      got = get_obs();
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL overlap_ones s=%0d got st=%b cnt=%0d z=%b%b%b hit=%0d req st=%b cnt=%0d z=%b%b%b hit=%0d",
                 i, got.st, got.cnt, got.z, got.z1, got.z0, got.hit,
                 exp.st, exp.cnt, exp.z, exp.z1, exp.z0, exp.hit);
      end else $display("overlap_ones s=%0d w=%b cnt=%0d z=%b hit=%0d ok", i, w_tab[i], got.cnt, got.z, got.hit);
    end
  endtask

  task automatic test_nonoverlap_zeros();
    obs_t got, exp;
    int cnt_tab [8] = '{1, 2, 3, 4, 1, 2, 3, 4};
    int hit_tab [8] = '{0, 0, 0, 1, 1, 1, 1, 2};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      sb_q.push_back(mk(3'b010, cnt_tab[i], hit_tab[i]));
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      got = get_obs();
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL nonoverlap_zeros s=%0d got st=%b cnt=%0d z=%b%b%b hit=%0d req st=%b cnt=%0d z=%b%b%b hit=%0d",
                 i, got.st, got.cnt, got.z, got.z1, got.z0, got.hit,
                 exp.st, exp.cnt, exp.z, exp.z1, exp.z0, exp.hit);
      end else $display("nonoverlap_zeros s=%0d cnt=%0d z=%b hit=%0d ok", i, got.cnt, got.z, got.hit);
    end
  endtask

  task automatic test_enable_gaps();
    obs_t got, exp;
    logic en_tab [9]  = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
    logic w_tab [9]   = '{1, 1, 0, 1, 0, 1, 0, 1, 1};
    int   cnt_tab [9] = '{1, 2, 2, 2, 2, 2, 2, 3, 4};
    int   hit_tab [9] = '{0, 0, 0, 0, 0, 0, 0, 0, 1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      sb_q.push_back(mk(3'b100, cnt_tab[i], hit_tab[i]));
      drive(1'b1, en_tab[i], w_tab[i], 1'b0, 1'b0);
      got = get_obs();
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL enable_gaps s=%0d got st=%b cnt=%0d z=%b%b%b hit=%0d req st=%b cnt=%0d z=%b%b%b hit=%0d",
                 i, got.st, got.cnt, got.z, got.z1, got.z0, got.hit,
                 exp.st, exp.cnt, exp.z, exp.z1, exp.z0, exp.hit);
      end else $display("enable_gaps s=%0d en=%b w=%b cnt=%0d z=%b ok", i, en_tab[i], w_tab[i], got.cnt, got.z);
    end
  endtask

  task automatic test_clear_collision();
    obs_t got, exp;
    logic       w_tab [10]   = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    logic       clr_tab [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic [2:0] st_tab [10]  = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b010,
                                 3'b100, 3'b100, 3'b100, 3'b001, 3'b100};
    int         cnt_tab [10] = '{1, 2, 3, 4, 1, 1, 2, 3, 0, 1};
    int         hit_tab [10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sb_q.push_back(mk(st_tab[i], cnt_tab[i], hit_tab[i]));
      drive(1'b1, 1'b1, w_tab[i], 1'b0, clr_tab[i]);
      got = get_obs();
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL clear_collision s=%0d got st=%b cnt=%0d z=%b%b%b hit=%0d req st=%b cnt=%0d z=%b%b%b hit=%0d",
                 i, got.st, got.cnt, got.z, got.z1, got.z0, got.hit,
                 exp.st, exp.cnt, exp.z, exp.z1, exp.z0, exp.hit);
      end else $display("clear_collision s=%0d clr=%b st=%b cnt=%0d ok", i, clr_tab[i], got.st, got.cnt);
    end
  endtask

  // Overlap toggled mid-run and back-to-back runs of opposite polarity.
  task automatic test_back_to_back();
    obs_t got, exp;
    logic       w_tab [10]   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic       ov_tab [10]  = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1};
    logic [2:0] st_tab [10]  = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100,
                                 3'b100, 3'b100, 3'b100, 3'b100, 3'b010};
    int         cnt_tab [10] = '{1, 2, 3, 4, 1, 2, 3, 4, 4, 1};
    int         hit_tab [10] = '{0, 0, 0, 1, 1, 1, 1, 2, 3, 3};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      sb_q.push_back(mk(st_tab[i], cnt_tab[i], hit_tab[i]));
      drive(1'b1, 1'b1, w_tab[i], ov_tab[i], 1'b0);
      got = get_obs();
      exp = sb_q.pop_front();
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL back_to_back s=%0d got st=%b cnt=%0d z=%b%b%b hit=%0d req st=%b cnt=%0d z=%b%b%b hit=%0d",
                 i, got.st, got.cnt, got.z, got.z1, got.z0, got.hit,
                 exp.st, exp.cnt, exp.z, exp.z1, exp.z0, exp.hit);
      end else $display("back_to_back s=%0d ov=%b cnt=%0d hit=%0d ok", i, ov_tab[i], got.cnt, got.hit);
    end
  endtask

  // Narrow counter instance: hit_count must stop at 3, z stays high.
  task automatic test_saturation();
    logic [1:0] got_hit, exp_hit;
    logic       exp_z;
    int         model_hit;
    do_reset();
    model_hit = 0;
    for (int i = 0; i < 10; i++) begin
      if (i >= 3 && model_hit < 3) model_hit++;
      sat_q.push_back(2'(model_hit));
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      got_hit = bus2.hit_count;
      exp_hit = sat_q.pop_front();
      exp_z   = (i >= 3);
      checks++;
      if (got_hit !== exp_hit || bus2.z !== exp_z) begin
        failures++;
        $display("FAIL saturation s=%0d got hit=%0d z=%b req hit=%0d z=%b",
                 i, got_hit, bus2.z, exp_hit, exp_z);
      end else $display("saturation s=%0d hit=%0d z=%b ok", i, got_hit, bus2.z);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    resetn   = 1'b0;
    bus.en = 1'b0;  bus.w = 1'b0;  bus.overlap = 1'b0;  bus.clear = 1'b0;
    bus2.en = 1'b0; bus2.w = 1'b0; bus2.overlap = 1'b0; bus2.clear = 1'b0;
    @(negedge clk);
    test_reset();
    test_overlap_ones();
    test_nonoverlap_zeros();
    test_enable_gaps();
    test_clear_collision();
    test_back_to_back();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/run_length_detector.md
# run_length_detector

Parametrised run-length sequence detector. It samples a serial input bit on qualified clock edges and flags when RUN_LEN consecutive equal bits have been seen, either all-zeros or all-ones. It is the generalised successor of the fixed four-in-a-row one-hot detector used on the board labs: run length is a parameter, it has overlap and non-overlap modes, a sample enable, a synchronous clear and a saturating hit counter. It sits between a debounced switch/serial source and LED or status logic.

## Interface
Parameters:
- RUN_LEN, default 4: consecutive equal bits required for a hit. Legal range is 2..255.
- HIT_W, default 8: width of hit_count.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- resetn  in  1  reset, synchronous, active-low.
- en  in  1  sample qualifier; w is consumed only when en=1.
- w  in  1  serial data bit.
- overlap  in  1  1 = overlapping detection, 0 = non-overlapping; sampled on each enabled edge.
- clear  in  1  synchronous soft clear of the detector state; hit_count is not affected.
- z  out  1  hit flag, registered (Moore).
- z_one  out  1  hit is a run of ones.
- z_zero  out  1  hit is a run of zeros.
- state  out  3  one-hot state: bit0 IDLE, bit1 RUN0, bit2 RUN1.
- run_cnt  out  $clog2(RUN_LEN+1)  current run length.
- hit_count  out  HIT_W  number of hits since reset, saturating.

## Operation
- States:
  - IDLE: no valid sample since reset or clear.
  - RUN0: tracking a run of zeros.
  - RUN1: tracking a run of ones.
- Reset (resetn=0 at an edge): state=IDLE (3'b001), run_cnt=0, z=z_one=z_zero=0, hit_count=0.
- Priority per edge: resetn, then clear, then en.
- clear=1: state=IDLE, run_cnt=0, z flags 0, hit_count held. An en sample in the same cycle is discarded.
- en=0: every register holds.
- en=1, from IDLE: go to RUN0 (w=0) or RUN1 (w=1), run_cnt=1.
- en=1 in RUNx with w differing from the current run: go to the other RUN state, run_cnt=1.
- en=1 in RUNx with w equal to the current run:
  - If run_cnt < RUN_LEN: run_cnt+1.
  - If run_cnt == RUN_LEN and overlap=1: run_cnt stays at RUN_LEN (saturates).
  - If run_cnt == RUN_LEN and overlap=0: run_cnt=1; the run restarts.
- z = (run_cnt == RUN_LEN), registered with the state. z_one = z & RUN1. z_zero = z & RUN0. z_one and z_zero are mutually exclusive.
- hit_count increments by 1 on every enabled edge where the next run_cnt equals RUN_LEN, excluding saturated holds where run_cnt is already RUN_LEN and overlap=1.
- In overlap mode, each extra equal bit after a hit counts as a new hit: next run_cnt equals RUN_LEN with the previous value also RUN_LEN, and a new bit was consumed. So each enabled equal-bit edge while saturated increments hit_count. This rule supersedes the exclusion above: increment whenever an enabled sample leaves run_cnt == RUN_LEN.
- hit_count saturates at all-ones and never wraps.
- Changing overlap mid-run affects only the edge on which it is sampled. No retroactive effect.

## Timing
- Latency: z asserts on the edge that consumes the RUN_LEN-th equal bit. It is visible in the cycle after that sample is presented.
- z deasserts on the edge that consumes a differing bit, a clear, a reset, or an equal bit in non-overlap mode once run_cnt wraps to 1.
- All outputs are registered. There is no combinational path from inputs to outputs.
- en gaps of any length are transparent: the run persists across idle cycles.
- One sample per enabled clock. There is no handshake back-pressure.

## Test plan
RUN_LEN=4 throughout.
- Reset: hold resetn=0 for 2 cycles with en=1, w=1 -> state=001, run_cnt=0, z=0, hit_count=0 throughout.
- Overlap ones: overlap=1, en=1, w=1,1,1,1,1,0 -> run_cnt 1,2,3,4,4,1. z high after samples 4 and 5 with z_one=1. hit_count ends at 2. Final state=100→010 (RUN0).
- Non-overlap zeros: overlap=0, w=0 ×8 -> run_cnt 1,2,3,4,1,2,3,4. z high after samples 4 and 8 only, with z_zero=1. hit_count=2.
- Enable gaps: w=1,1 then en=0 for 5 cycles with w toggling, then w=1,1 -> z high after the 4th enabled sample. The disabled cycles have no effect.
- Clear collision: build run_cnt=3 on ones, then clear=1 with en=1, w=1 -> state=001, run_cnt=0, z=0, hit_count unchanged. The next sample w=1 gives run_cnt=1.
- Saturation: HIT_W=2, overlap=1, w=1 ×10 -> hit_count 1,2,3, then stays 3. z remains high from sample 4 onward.
